des_key_schedule: RTL and testbench
===================================

# des_key_schedule

Sequential DES key-schedule generator that sits directly upstream of the encryption datapath. It accepts one 64-bit DES key, with parity, through a valid/ready handshake and applies PC-1. It then streams the 16 48-bit round subkeys through a second valid/ready handshake, one per transfer. In decrypt mode it emits them in reverse order (K16 first) using right rotations, so the round datapath never needs a subkey store.

## Interface
- CHECK_PARITY, default 1: 1 enables odd-parity checking of each key byte; 0 ties parity_err low.
- clk  input  1  rising-edge clock.
- rst  input  1  reset, synchronous and active-high.
- key_valid  input  1  key and decrypt are valid.
- key_ready  output  1  block can accept a key; high only in IDLE and not in reset.
- key  input  64  DES key; DES bit 1 = key[63], parity bits are key[56], key[48], …, key[0].
- decrypt  input  1  sampled with key; 0 = K1..K16, 1 = K16..K1.
- sk_valid  output  1  subkey is valid.
- sk_ready  input  1  consumer accepts the subkey.
- subkey  output  48  PC-2 output; DES bit 1 = subkey[47].
- sk_round  output  4  DES round number minus 1 of the presented subkey.
- sk_last  output  1  high with the 16th subkey of the sequence.
- parity_err  output  1  the accepted key had at least one even-parity byte; held for the whole sequence.

## Operation
- FSM states:
  - IDLE → RUN on key_valid && key_ready.
  - RUN → IDLE on sk_valid && sk_ready && sk_last.
- Registers: C, D (28 bits each), a 4-bit round index, the direction bit, and the parity flag.
- Rotation schedule s(r): 1 for rounds r = 1, 2, 9, 16; 2 otherwise. The total over 16 rounds is 28.
- Accept, encrypt: load C, D = rotl(PC-1(key), 1), i.e. C1/D1; set round = 0.
- Accept, decrypt: load C, D = PC-1(key), since C16 = C0; set round = 15.
- subkey = PC-2(C, D), driven combinationally from the registers.
- Advance on each sk_valid && sk_ready while not last:
  - Encrypt: rotate left by s(round+2), then round += 1.
  - Decrypt: rotate right by s(round+1), then round −= 1.
- sk_last = (encrypt && round == 15) || (decrypt && round == 0).
- Parity bits (key bits 8, 16, …, 64) are discarded by PC-1, so they never affect subkeys.
- key, decrypt and key_valid are ignored while key_ready is low.

## Timing
- Reset values: sk_valid=0, sk_last=0, sk_round=0, subkey=0, parity_err=0, key_ready=0 while rst is high. State = IDLE, so key_ready=1 on the first cycle after rst drops.
- Key accepted at edge N: sk_valid=1 from cycle N+1, showing the first subkey.
- One subkey per cycle when sk_ready is held high. A full sequence occupies 16 cycles after acceptance, and key_ready returns high the cycle after the final transfer. Minimum key-to-key spacing is 17 cycles, with no overlap.
- Back-pressure: while sk_valid && !sk_ready, subkey, sk_round, sk_last and parity_err hold stable.
- sk_valid never drops mid-sequence except on reset.
- Reset mid-sequence aborts at the next edge: sk_valid=0, the remaining subkeys are never emitted, and a new key is accepted normally afterwards.

## Structure
- Shared package des_pkg holds:
  - PC1 (56 entries) and PC2 (48 entries) index tables.
  - SHIFTS[1:16] table.
  - FSM state enum {IDLE, RUN}.
  - Width constants for key, half-key and subkey.
- Sub-module des_pc2: combinational 56→48 PC-2 permutation, reusable by other stages.
- PC-1, rotations and the parity XOR-reduce stay inline.

## Test plan
- Encrypt, key 133457799BBCDFF1, sk_ready=1 → sk_valid from the cycle after accept. First subkey = 1B02EFFC7072, round 0. Second = 79AED9DBC9E5. Sixteenth = CB3D8B0E17F5 with sk_last=1. parity_err=0 throughout.
- Decrypt, same key → first subkey CB3D8B0E17F5 with sk_round=15. Second = K15 with sk_round=14. Last = 1B02EFFC7072 with sk_round=0 and sk_last=1. The full sequence is exactly the encrypt sequence reversed.
- Key 123457799BBCDFF1 (byte 0x12 has even parity) → parity_err=1 on all 16 subkeys. Subkeys are identical to the first scenario.
- Random sk_ready toggling → subkey and sk_round stable while stalled, no subkey skipped or duplicated, and key_valid ignored until key_ready returns high.
- rst asserted after the 5th transfer → sk_valid=0 the next cycle and key_ready=1 after rst drops. A new key (decrypt) then yields CB3D8B0E17F5 first.
- Back-to-back keys with key_valid held high → second accept occurs exactly one cycle after the first sequence's sk_last transfer.

Source files
------------

// File: rtl/des_pkg.sv
// Shared DES key-schedule constants: permutation tables, shift schedule, FSM states.
package des_pkg;

  localparam int unsigned KeyW    = 64;
  localparam int unsigned HalfW   = 28;
  localparam int unsigned CdW     = 56;
  localparam int unsigned SubkeyW = 48;
  localparam int unsigned RoundW  = 4;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  // Entries are DES bit numbers (1 = MSB) of the source vector.
  localparam int unsigned PC1 [CdW] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int unsigned PC2 [SubkeyW] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  // Per-round left-rotation amount, indexed by DES round number.
  localparam int unsigned SHIFTS [1:16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  // Rotate a 28-bit half left by 1 or 2.
  function automatic logic [HalfW-1:0] rotl(input logic [HalfW-1:0] x, input int unsigned n);
    return (n == 2) ? {x[HalfW-3:0], x[HalfW-1:HalfW-2]} : {x[HalfW-2:0], x[HalfW-1]};
  endfunction

  // Rotate a 28-bit half right by 1 or 2.
  function automatic logic [HalfW-1:0] rotr(input logic [HalfW-1:0] x, input int unsigned n);
    return (n == 2) ? {x[1:0], x[HalfW-1:2]} : {x[0], x[HalfW-1:1]};
  endfunction

endpackage

// File: rtl/des_key_schedule_if.sv
// Key-in and subkey-out handshakes of the DES key schedule.
interface des_key_schedule_if;
  import des_pkg::*;

  logic                 key_valid;
  logic                 key_ready;
  logic [KeyW-1:0]      key;
  logic                 decrypt;
  logic                 sk_valid;
  logic                 sk_ready;
  logic [SubkeyW-1:0]   subkey;
  logic [RoundW-1:0]    sk_round;
  logic                 sk_last;
  logic                 parity_err;

  modport master (
    output key_valid, key, decrypt, sk_ready,
    input  key_ready, sk_valid, subkey, sk_round, sk_last, parity_err
  );

  modport slave (
    input  key_valid, key, decrypt, sk_ready,
    output key_ready, sk_valid, subkey, sk_round, sk_last, parity_err
  );

endinterface

// File: rtl/des_pc2.sv
// Combinational DES PC-2: 56-bit C||D to 48-bit round subkey.
module des_pc2
  import des_pkg::*;
(
  input  logic [CdW-1:0]     cd_i,
  output logic [SubkeyW-1:0] subkey_o
);

  // Table bit p (1 = MSB) lives at vector index width - p.
  always_comb begin
    subkey_o = '0;
    for (int j = 0; j < SubkeyW; j++) begin
      subkey_o[SubkeyW-1-j] = cd_i[CdW-PC2[j]];
    end
  end

endmodule

// File: rtl/des_key_schedule.sv
// Sequential DES key schedule: accepts a key, streams 16 subkeys in encrypt or decrypt order.
module des_key_schedule
  import des_pkg::*;
#(
  parameter bit CHECK_PARITY = 1'b1
) (
  input logic               clk,
  input logic               rst,
  des_key_schedule_if.slave bus
);

  state_e              state_q, state_d;
  logic [HalfW-1:0]    c_q, c_d, d_q, d_d;
  logic [RoundW-1:0]   round_q, round_d;
  logic                dec_q, dec_d;
  logic                perr_q, perr_d;

  logic [CdW-1:0]      pc1;
  logic [SubkeyW-1:0]  pc2_out;
  logic                key_par_err;
  logic                key_ready, sk_valid, last, accept, advance;

  // PC-1: drop parity bits and split the key into C0||D0.
  always_comb begin
    pc1 = '0;
    for (int j = 0; j < CdW; j++) begin
      pc1[CdW-1-j] = bus.key[KeyW-PC1[j]];
    end
  end

  // Flag any key byte with even parity.
  always_comb begin
    key_par_err = 1'b0;
    for (int b = 0; b < 8; b++) begin
      if (!(^bus.key[8*b +: 8])) key_par_err = 1'b1;
    end
    if (!CHECK_PARITY) key_par_err = 1'b0;
  end

  des_pc2 u_pc2 (
    .cd_i     ({c_q, d_q}),
    .subkey_o (pc2_out)
  );

  // Handshake qualifiers; outputs are forced quiet while reset is held.
  always_comb begin
    key_ready = (state_q == StIdle) && !rst;
    sk_valid  = (state_q == StRun) && !rst;
    last      = dec_q ? (round_q == '0) : (round_q == RoundW'(15));
    accept    = bus.key_valid && key_ready;
    advance   = sk_valid && bus.sk_ready;
  end

  // Drive the interface outputs from registered state.
  always_comb begin
    bus.key_ready  = key_ready;
    bus.sk_valid   = sk_valid;
    bus.sk_last    = sk_valid && last;
    bus.subkey     = rst ? '0 : pc2_out;
    bus.sk_round   = rst ? '0 : round_q;
    bus.parity_err = rst ? 1'b0 : perr_q;
  end

  // Next-state: load on accept, rotate one round per transfer.
  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    d_d     = d_q;
    round_d = round_q;
    dec_d   = dec_q;
    perr_d  = perr_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StRun;
          dec_d   = bus.decrypt;
          perr_d  = key_par_err;
          if (bus.decrypt) begin
            // C16/D16 equal C0/D0 since the shifts total 28.
            c_d     = pc1[CdW-1:HalfW];
            d_d     = pc1[HalfW-1:0];
            round_d = RoundW'(15);
          end else begin
            c_d     = rotl(pc1[CdW-1:HalfW], 1);
            d_d     = rotl(pc1[HalfW-1:0], 1);
            round_d = '0;
          end
        end
      end
      StRun: begin
        if (advance) begin
          if (last) begin
            state_d = StIdle;
          end else if (dec_q) begin
            c_d     = rotr(c_q, SHIFTS[{1'b0, round_q} + 5'd1]);
            d_d     = rotr(d_q, SHIFTS[{1'b0, round_q} + 5'd1]);
            round_d = round_q - RoundW'(1);
          end else begin
            c_d     = rotl(c_q, SHIFTS[{1'b0, round_q} + 5'd2]);
            d_d     = rotl(d_q, SHIFTS[{1'b0, round_q} + 5'd2]);
            round_d = round_q + RoundW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      c_q     <= '0;
      d_q     <= '0;
      round_q <= '0;
      dec_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      d_q     <= d_d;
      round_q <= round_d;
      dec_q   <= dec_d;
      perr_q  <= perr_d;
    end
  end

endmodule

// File: tb/tb_des_key_schedule.sv
// Directed scoreboard bench for des_key_schedule.
module tb_des_key_schedule;
  import des_pkg::*;

  typedef struct packed {
    logic [47:0] sk;
    logic [3:0]  rnd;
    logic        last;
    logic        perr;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  des_key_schedule_if ks_if ();

  des_key_schedule #(.CHECK_PARITY(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ks_if)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int xfers  = 0;
  exp_t q[$];

  // Reference subkeys K1..K16 for key 133457799BBCDFF1.
  logic [47:0] ktab [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
  };

  localparam logic [63:0] KeyGood = 64'h133457799BBCDFF1;
  localparam logic [63:0] KeyPar  = 64'h123457799BBCDFF1;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_seq(input bit dec, input bit perr);
    for (int i = 0; i < 16; i++) begin
      int   r;
      exp_t e;
      r      = dec ? 15 - i : i;
      e.sk   = ktab[r];
      e.rnd  = r[3:0];
      e.last = (i == 15);
      e.perr = perr;
      q.push_back(e);
    end
  endtask

  // Present a key and return at posedge+1 after the accepting edge.
  task automatic send_key(input logic [63:0] k, input bit dec, input bit hold);
    ks_if.key       = k;
    ks_if.decrypt   = dec;
    ks_if.key_valid = 1'b1;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (ks_if.key_ready) break;
    end
    check("key_ready_seen", ks_if.key_ready, 1);
    @(posedge clk);
    #1;
    if (!hold) ks_if.key_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int n = 0; n < 300; n++) begin
      @(posedge clk);
      #1;
      if (q.size() == 0) break;
    end
    check(tag, q.size(), 0);
    check({tag, "_key_ready"}, ks_if.key_ready, 1);
  endtask

  // Monitor: pop and compare on every transfer, verify hold during stalls.
  exp_t        mon_e;
  logic        stalled = 1'b0;
  logic [47:0] s_sk;
  logic [3:0]  s_rnd;
  logic        s_last, s_perr;

  always @(negedge clk) begin
    if (!rst && ks_if.sk_valid) begin
      if (stalled) begin
        check("hold_subkey", ks_if.subkey, s_sk);
        check("hold_round", ks_if.sk_round, s_rnd);
        check("hold_last", ks_if.sk_last, s_last);
        check("hold_perr", ks_if.parity_err, s_perr);
      end
      if (ks_if.sk_ready) begin
        xfers++;
        check("sb_nonempty", q.size() > 0, 1);
        if (q.size() > 0) begin
          mon_e = q.pop_front();
          check("subkey", ks_if.subkey, mon_e.sk);
          check("sk_round", ks_if.sk_round, mon_e.rnd);
          check("sk_last", ks_if.sk_last, mon_e.last);
          check("parity_err", ks_if.parity_err, mon_e.perr);
        end
      end
      stalled = !ks_if.sk_ready;
      s_sk    = ks_if.subkey;
      s_rnd   = ks_if.sk_round;
      s_last  = ks_if.sk_last;
      s_perr  = ks_if.parity_err;
    end else begin
      stalled = 1'b0;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int x0, acc1, acc2;
    rst             = 1'b1;
    ks_if.key_valid = 1'b0;
    ks_if.key       = '0;
    ks_if.decrypt   = 1'b0;
    ks_if.sk_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_sk_valid", ks_if.sk_valid, 0);
    check("rst_key_ready", ks_if.key_ready, 0);
    check("rst_sk_last", ks_if.sk_last, 0);
    check("rst_sk_round", ks_if.sk_round, 0);
    check("rst_subkey", ks_if.subkey, 0);
    check("rst_parity_err", ks_if.parity_err, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_key_ready", ks_if.key_ready, 1);

    // Encrypt sequence, consumer always ready.
    ks_if.sk_ready = 1'b1;
    push_seq(0, 0);
    send_key(KeyGood, 0, 0);
    check("enc_first_valid", ks_if.sk_valid, 1);
    check("enc_busy_key_ready", ks_if.key_ready, 0);
    drain("enc_drain");

    // Decrypt sequence: same subkeys reversed.
    push_seq(1, 0);
    send_key(KeyGood, 1, 0);
    check("dec_first_valid", ks_if.sk_valid, 1);
    drain("dec_drain");

    // Even-parity byte: same subkeys, parity flag held.
    push_seq(0, 1);
    send_key(KeyPar, 0, 0);
    drain("par_drain");

    // Random back-pressure with a spurious key offered mid-sequence.
    push_seq(1, 0);
    send_key(KeyGood, 1, 0);
    for (int n = 0; n < 300; n++) begin
      ks_if.sk_ready = 1'($urandom_range(0, 1));
      if (n >= 3 && n <= 8) begin
        ks_if.key       = 64'h0123456789ABCDEF;
        ks_if.decrypt   = 1'b0;
        ks_if.key_valid = 1'b1;
        check("busy_key_ready", ks_if.key_ready, 0);
      end else begin
        ks_if.key_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      if (q.size() == 0) break;
    end
    ks_if.key_valid = 1'b0;
    ks_if.sk_ready  = 1'b1;
    check("stall_drain", q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
    check("stall_idle_valid", ks_if.sk_valid, 0);

    // Reset after the fifth transfer aborts the sequence.
    push_seq(0, 0);
    x0 = xfers;
    send_key(KeyGood, 0, 0);
    for (int n = 0; n < 60; n++) begin
      @(posedge clk);
      #1;
      if (xfers >= x0 + 5) break;
    end
    check("abort_xfers", xfers - x0, 5);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_sk_valid", ks_if.sk_valid, 0);
    q.delete();
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("abort_key_ready", ks_if.key_ready, 1);
    push_seq(1, 0);
    send_key(KeyGood, 1, 0);
    drain("abort_dec_drain");

    // Back-to-back keys with key_valid held high.
    push_seq(0, 0);
    push_seq(1, 0);
    send_key(KeyGood, 0, 1);
    acc1 = cyc;
    ks_if.decrypt = 1'b1;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (ks_if.key_ready) break;
    end
    check("b2b_key_ready", ks_if.key_ready, 1);
    @(posedge clk);
    #1;
    acc2 = cyc;
    ks_if.key_valid = 1'b0;
    check("b2b_spacing", acc2 - acc1, 17);
    drain("b2b_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
